// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch unit and the back-end units.
// Contents:
//   - opcode constants (instruction class in [15:14], memory sub-op in [13:12])
//   - fetch_state_t, the fetch-stage state encoding
//   - bus/instruction width constants
//   - is_mem_op(), the instruction-class decode shared by the units
package cpu_pkg;

    localparam int INSTR_W = 16;
    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 8;

    // Instruction class carried in ir[15:14]
    localparam logic [1:0] OP_MEM    = 2'b01;
    // Memory sub-operation carried in ir[13:12] of an OP_MEM instruction
    localparam logic [1:0] MEM_READ  = 2'b00;
    localparam logic [1:0] MEM_WRITE = 2'b01;

    typedef enum logic [2:0] {
        REQ_LO = 3'd0,
        CAP_LO = 3'd1,
        REQ_HI = 3'd2,
        CAP_HI = 3'd3,
        EXEC   = 3'd4
    } fetch_state_t;

    // True when the instruction belongs to the memory class
    function automatic logic is_mem_op(input logic [INSTR_W-1:0] ir);
        return (ir[15:14] == OP_MEM);
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage.
// Reads each 16-bit instruction as two bytes (little-endian) over the shared
// 8-bit memory bus, presents it on `instruction` for one execute window and
// then advances or redirects the program counter. While a memory-class
// instruction executes, all fetch-side bus outputs float so the load/store
// unit can own the bus.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   memory_data_bus      - shared read data (input only)
//   memory_address_bus   - tri-state address, driven while this block owns the bus
//   memory_enable        - tri-state memory select
//   memory_write_enable  - tri-state write enable, always 0 when owned
//   instruction          - current instruction, 0 outside the execute window
//   instr_valid          - high during the execute window
//   pc                   - address of the current or next instruction
//   jump_en, jump_addr   - redirect request, honoured on the last execute cycle
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC        = 16'h0000,
    parameter int          MEM_EXEC_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATA_W-1:0]   memory_data_bus,
    output logic [ADDR_W-1:0]   memory_address_bus,
    output logic                memory_enable,
    output logic                memory_write_enable,
    output logic [INSTR_W-1:0]  instruction,
    output logic                instr_valid,
    output logic [ADDR_W-1:0]   pc,
    input  logic                jump_en,
    input  logic [ADDR_W-1:0]   jump_addr
);

    // Counter value on the final cycle of a memory-class execute window
    localparam logic [1:0] CNT_LAST = 2'(MEM_EXEC_CYCLES - 1);

    fetch_state_t        state_q, state_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [INSTR_W-1:0]  ir_q, ir_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic                valid_q, valid_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                en_q, en_d;
    logic                own_q, own_d;
    logic                last_exec_s;
    logic [ADDR_W-1:0]   next_pc_s;

    // Final execute cycle: memory ops stay MEM_EXEC_CYCLES cycles, others one
    always_comb begin
        if (is_mem_op(ir_q)) begin
            last_exec_s = (cnt_q == CNT_LAST);
        end else begin
            last_exec_s = 1'b1;
        end
    end

    // Redirect target or sequential successor (16-bit modulo)
    always_comb begin
        if (jump_en) begin
            next_pc_s = jump_addr;
        end else begin
            next_pc_s = pc_q + 16'd2;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= REQ_LO;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            REQ_LO:  state_d = CAP_LO;
            CAP_LO:  state_d = REQ_HI;
            REQ_HI:  state_d = CAP_HI;
            CAP_HI:  state_d = EXEC;
            EXEC: begin
                if (last_exec_s) begin
                    state_d = REQ_LO;
                end else begin
                    state_d = EXEC;
                end
            end
            default: state_d = REQ_LO;
        endcase
    end

    // Output / datapath next values for each state
    always_comb begin
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        instr_d = instr_q;
        valid_d = valid_q;
        addr_d  = addr_q;
        en_d    = en_q;
        case (state_q)
            REQ_LO: begin
                addr_d = pc_q;
                en_d   = 1'b1;
            end
            CAP_LO: begin
                ir_d[7:0] = memory_data_bus;
            end
            REQ_HI: begin
                addr_d = pc_q + 16'd1;
                en_d   = 1'b1;
            end
            CAP_HI: begin
                // The high byte goes straight into instruction as well, so
                // the execute window opens on the very next edge.
                ir_d[15:8] = memory_data_bus;
                instr_d    = {memory_data_bus, ir_q[7:0]};
                valid_d    = 1'b1;
                addr_d     = pc_q;
                en_d       = 1'b0;
                cnt_d      = 2'd0;
            end
            EXEC: begin
                if (last_exec_s) begin
                    pc_d    = next_pc_s;
                    instr_d = 16'h0000;
                    valid_d = 1'b0;
                    addr_d  = next_pc_s;
                    en_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            default: begin
                instr_d = 16'h0000;
                valid_d = 1'b0;
                en_d    = 1'b0;
            end
        endcase
        // Bus ownership comes from state and ir only, never from instruction,
        // so the load/store unit cannot close a combinational loop through it.
        if ((state_d == EXEC) && is_mem_op(ir_d)) begin
            own_d = 1'b0;
        end else begin
            own_d = 1'b1;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= 2'd0;
            pc_q    <= RESET_PC;
            ir_q    <= 16'h0000;
            instr_q <= 16'h0000;
            valid_q <= 1'b0;
            addr_q  <= RESET_PC;
            en_q    <= 1'b0;
            own_q   <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            en_q    <= en_d;
            own_q   <= own_d;
        end
    end

    assign memory_address_bus  = own_q ? addr_q : 16'hzzzz;
    assign memory_enable       = own_q ? en_q   : 1'bz;
    assign memory_write_enable = own_q ? 1'b0   : 1'bz;
    assign instruction         = instr_q;
    assign instr_valid         = valid_q;
    assign pc                  = pc_q;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of the load/store unit and the other back-end units. It reads each 16-bit instruction as two bytes over the shared 8-bit memory bus, presents it on `instruction` for a fixed execute window, and advances or redirects the program counter. The memory bus is released to the load/store unit while a memory-class instruction (opcode bits [15:14] = 2'b01) executes.

## Interface
- `RESET_PC`, 16'h0000: program counter value after reset.
- `MEM_EXEC_CYCLES`, 2: execute-window length for opcode 01. Must be 2 to match the load/store unit's two-phase sequence.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `memory_data_bus` input 8: shared data bus; this block only reads it.
- `memory_address_bus` output 16: tri-state; driven when the fetch unit owns the bus.
- `memory_enable` output 1: tri-state memory select.
- `memory_write_enable` output 1: tri-state; always driven 0 when owned.
- `instruction` output 16: current instruction to the back end.
- `instr_valid` output 1: high during the execute window.
- `pc` output 16: address of the current or next instruction.
- `jump_en` input 1: redirect request from the back end.
- `jump_addr` input 16: redirect target.

## Operation
- States: REQ_LO, CAP_LO, REQ_HI, CAP_HI, EXEC.
- REQ_LO: register `memory_address_bus <= pc` and `memory_enable <= 1`.
- CAP_LO: sample `memory_data_bus` into `ir[7:0]`.
- REQ_HI: address `pc + 1`, enable 1.
- CAP_HI: sample `memory_data_bus` into `ir[15:8]`, then deassert enable.
- Byte order: little-endian; low byte at `pc`, high byte at `pc + 1`.
- EXEC: `instruction = ir` and `instr_valid = 1`.
  - Opcode 01: the window lasts `MEM_EXEC_CYCLES` cycles, and all three memory outputs are 'z so the load/store unit owns the bus.
  - Other opcodes: the window lasts 1 cycle, and the block drives enable 0, write enable 0, address = `pc`.
- Outside EXEC, `instruction` = 16'h0000 (opcode 00). This keeps every back-end unit idle and stops the load/store unit from driving the bus during a fetch.
- On the last EXEC cycle the state returns to REQ_LO:
  - `jump_en` = 1: `pc <= jump_addr`.
  - Otherwise: `pc <= pc + 2`.
- `jump_en` is ignored in every other state and in non-final EXEC cycles.
- PC arithmetic is 16-bit modulo. `pc` = 16'hFFFF fetches its high byte from 16'h0000, and `pc + 2` wraps the same way.
- An odd `jump_addr` is accepted unmodified.

## Timing
- Reset values:
  - state REQ_LO, `pc` = `RESET_PC`, `ir` = 0, `instruction` = 0, `instr_valid` = 0.
  - Memory outputs driven: address `RESET_PC`, enable 0, write enable 0.
- Read protocol: data is valid on `memory_data_bus` in the cycle after the edge that registered address and enable high. It is sampled at the following edge.
- Fetch takes 4 cycles.
  - Non-memory instruction: 5 cycles per instruction.
  - Memory instruction: 6 cycles per instruction.
- `instruction` changes only on the edges entering and leaving EXEC, and is stable for the whole window.
- A reset asserted mid-fetch or mid-EXEC takes effect immediately and asynchronously:
  - bus reclaimed, `instruction` forced to 0, partial `ir` discarded;
  - the fetch restarts at `RESET_PC` on the first edge after `rst_n` rises.

## Structure
- Shared package `cpu_pkg` holds:
  - opcode constants: `OP_MEM` = 2'b01, `MEM_READ` = 2'b00, `MEM_WRITE` = 2'b01;
  - the fetch state enum `fetch_state_t`;
  - width constants: `INSTR_W` = 16, `ADDR_W` = 16, `DATA_W` = 8.
- The load/store unit imports the same opcode constants.
- Single module; no sub-module is warranted.
- Tri-state enables are decoded from state plus `ir[15:14]` only. They must never depend on `instruction`, so enables cannot loop combinationally through the load/store unit.

## Test plan
- Reset release, memory[0]=8'h34, memory[1]=8'h12 -> `instruction` = 16'h1234 and `instr_valid` = 1 exactly on cycle 5 for 1 cycle; `pc` then becomes 16'h0002.
- Instruction 16'h4405 (load, opcode 01) at address 0 -> `instr_valid` high 2 cycles; all fetch memory outputs 'z during EXEC; the load/store unit reads address 16'h0005; next fetch at 16'h0002.
- `jump_en` = 1, `jump_addr` = 16'h0100 during the single EXEC cycle of 16'h0000 -> next REQ_LO drives address 16'h0100; `jump_en` pulsed during CAP_HI -> no effect.
- `RESET_PC` = 16'hFFFF -> bytes fetched from 16'hFFFF then 16'h0000; next `pc` = 16'h0001.
- `rst_n` low during CAP_HI -> immediately `instruction` = 0, enable 0, `instr_valid` = 0; after release, the first address is `RESET_PC`.
- Back-to-back mixed stream (load, add, store, add) -> `instruction` = 0 between every EXEC window; no cycle where both units drive the bus.
